// File: rtl/video_fetch_fifo_if.sv
// Read-request bus between the frame fetcher (master) and main RAM (slave).
// data_in is valid in the same cycle as data_ready.
`timescale 1ns/1ps
interface video_fetch_fifo_if #(
  parameter int unsigned ADDR_WIDTH = 30
);
  logic                  addr_strobe;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  data_ready;
  logic [31:0]           data_in;

  modport master (output addr_strobe, output addr, input data_ready, input data_in);
  modport slave  (input addr_strobe, input addr, output data_ready, output data_in);
endinterface

// File: rtl/video_fetch_fifo.sv
// Frame-buffer fetcher with a show-ahead prefetch FIFO feeding the display stage.
// Define VIDEO_FETCH_UNDERRUN_CNT_EN to build the saturating underrun counter.
`timescale 1ns/1ps
module video_fetch_fifo #(
  parameter int unsigned ADDR_WIDTH  = 30,
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned FRAME_WORDS = 38400
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  vsync,
  input  logic                  rd,
  video_fetch_fifo_if.master    bus,
  output logic [7:0]            red_byte,
  output logic [7:0]            green_byte,
  output logic [7:0]            blue_byte,
  output logic [7:0]            bright_byte,
  output logic                  underrun,
  output logic [15:0]           underrun_count
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam int unsigned WI_W  = $clog2(FRAME_WORDS + 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic                  vs_meta_q, vs_s_q, vs_prev_q;
  logic [ADDR_WIDTH-1:0] addr_ptr_q, addr_ptr_d;
  logic [WI_W-1:0]       issued_q, issued_d;
  logic [DEPTH_LOG2-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  underrun_q, underrun_d;
  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           head_word;
  logic                  fs, empty, pop, wr_en, restart;

  assign fs    = vs_prev_q & ~vs_s_q;
  assign empty = (count_q == '0);
  assign pop   = rd & ~empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_meta_q  <= 1'b1;
      vs_s_q     <= 1'b1;
      vs_prev_q  <= 1'b1;
      state_q    <= IDLE;
      addr_ptr_q <= '0;
      issued_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      vs_meta_q  <= vsync;
      vs_s_q     <= vs_meta_q;
      vs_prev_q  <= vs_s_q;
      state_q    <= state_d;
      addr_ptr_q <= addr_ptr_d;
      issued_q   <= issued_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[tail_q] <= bus.data_in;
  end

  always_comb begin
    state_d    = state_q;
    addr_ptr_d = addr_ptr_q;
    issued_d   = issued_q;
    restart    = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      IDLE, DONE: if (fs) restart = 1'b1;
      FETCH: begin
        if (fs)                                     restart = 1'b1;
        else if (issued_q == WI_W'(FRAME_WORDS))    state_d = DONE;
        else if (count_q < CNT_W'(DEPTH))           state_d = WAIT;
      end
      WAIT: begin
        // A frame start that lands on the ack cycle discards the word directly.
        if (bus.data_ready) begin
          if (fs) restart = 1'b1;
          else begin
            wr_en      = 1'b1;
            addr_ptr_d = addr_ptr_q + ADDR_WIDTH'(1);
            issued_d   = issued_q + WI_W'(1);
            state_d    = FETCH;
          end
        end else if (fs) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   if (bus.data_ready) restart = 1'b1;
      default: state_d = IDLE;
    endcase
    if (restart) begin
      state_d    = FETCH;
      addr_ptr_d = base_addr;
      issued_d   = '0;
    end

    head_d  = head_q + DEPTH_LOG2'(pop);
    tail_d  = tail_q + DEPTH_LOG2'(wr_en);
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    if (restart) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end

    underrun_d = underrun_q;
    if (fs)              underrun_d = 1'b0;
    else if (rd && empty) underrun_d = 1'b1;
  end

  assign bus.addr_strobe = (state_q == WAIT) || (state_q == DRAIN);
  assign bus.addr        = addr_ptr_q;

  assign head_word   = empty ? '0 : mem_q[head_q];
  assign red_byte    = head_word[7:0];
  assign green_byte  = head_word[15:8];
  assign blue_byte   = head_word[23:16];
  assign bright_byte = head_word[31:24];
  assign underrun    = underrun_q;

`ifdef VIDEO_FETCH_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (rd && empty && (ucnt_q != '1)) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ucnt_q <= '0;
    else          ucnt_q <= ucnt_d;
  end

  assign underrun_count = ucnt_q;
`else
  assign underrun_count = '0;
`endif
endmodule
